// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared definitions for the system-bus arbiter and the cache
// controllers that talk to it.
//   SYS_DATA_W    - request/response data width
//   SYS_TAG_W     - tag width
//   TAG_WRITE_BIT - tag bit that marks a write transaction
//   BEATS         - data beats per transaction (one 64-byte line)
//   BEAT_W        - width of a beat counter that can hold BEATS
//   arb_state_t   - arbiter FSM states
package sysbus_pkg;

    localparam int SYS_DATA_W    = 64;
    localparam int SYS_TAG_W     = 13;
    localparam int TAG_WRITE_BIT = SYS_TAG_W - 1;
    localparam int BEATS         = 8;
    localparam int BEAT_W        = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sysbus_arbiter_if.sv
// sysbus_arbiter_if: one system-bus port (request and response channels).
//   reqcyc/req/reqtag  - request beat valid, address or write data, tag
//   reqack             - request beat accepted
//   respcyc/resp/resptag - response beat valid, data, tag
//   respack            - response beat accepted
// modport master: the side that issues requests (a cache path, or the
//                 arbiter towards the system bus).
// modport slave : the side that serves requests.
interface sysbus_arbiter_if #(
    parameter int DW = sysbus_pkg::SYS_DATA_W,
    parameter int TW = sysbus_pkg::SYS_TAG_W
);
    logic          reqcyc;
    logic [DW-1:0] req;
    logic [TW-1:0] reqtag;
    logic          reqack;
    logic          respcyc;
    logic [DW-1:0] resp;
    logic [TW-1:0] resptag;
    logic          respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   i_req[1:0]    - request lines
//   i_last        - index granted most recently
//   o_grant_valid - at least one request present
//   o_grant_idx   - chosen index; on a tie the one that is not i_last
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_grant_valid,
    output logic       o_grant_idx
);

    // Pick a requester, rotating priority away from the last winner.
    always_comb begin
        o_grant_valid = |i_req;
        if (i_req == 2'b11) begin
            o_grant_idx = ~i_last;
        end else if (i_req[1]) begin
            o_grant_idx = 1'b1;
        end else begin
            o_grant_idx = 1'b0;
        end
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares the system-bus master port between the
// instruction-fetch path (c0) and the data-cache path (c1), one whole
// transaction at a time (address beat plus BEATS data or response beats).
//   clk   - clock
//   reset - asynchronous active-high reset
//   c0    - requester 0 port (arbiter is the slave)
//   c1    - requester 1 port (arbiter is the slave)
//   bus   - system-bus port (arbiter is the master)
// Handshake paths are combinational from the registered state, so every
// output collapses to 0 as soon as reset forces the FSM to IDLE.
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = sysbus_pkg::SYS_DATA_W,
    parameter int BUS_TAG_WIDTH  = sysbus_pkg::SYS_TAG_W,
    parameter int BEATS          = sysbus_pkg::BEATS
) (
    input  logic             clk,
    input  logic             reset,
    sysbus_arbiter_if.slave  c0,
    sysbus_arbiter_if.slave  c1,
    sysbus_arbiter_if.master bus
);
    import sysbus_pkg::*;

    localparam int BW = $clog2(BEATS) + 1;

    arb_state_t r_state;
    logic       r_owner;
    logic       r_last;
    logic       r_is_wr;
    logic [BW-1:0] r_beat;

    arb_state_t w_next_state;
    logic       w_next_owner;
    logic       w_next_last;
    logic       w_next_is_wr;
    logic [BW-1:0] w_next_beat;

    logic       w_grant_valid;
    logic       w_grant_idx;
    logic       w_pick_wr;
    logic       w_own_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] w_own_req;
    logic [BUS_TAG_WIDTH-1:0]  w_own_reqtag;
    logic       w_own_respack;
    logic       w_last_beat;

    rr_pick2 u_pick (
        .i_req         ({c1.reqcyc, c0.reqcyc}),
        .i_last        (r_last),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    // Response data and tag go to both requesters; only respcyc is routed.
    assign c0.resp    = bus.resp;
    assign c0.resptag = bus.resptag;
    assign c1.resp    = bus.resp;
    assign c1.resptag = bus.resptag;

    assign w_last_beat = (r_beat == BW'(BEATS - 1));

    // Owner-side request/ack selection and write flag of the candidate.
    always_comb begin
        if (r_owner) begin
            w_own_reqcyc  = c1.reqcyc;
            w_own_req     = c1.req;
            w_own_reqtag  = c1.reqtag;
            w_own_respack = c1.respack;
        end else begin
            w_own_reqcyc  = c0.reqcyc;
            w_own_req     = c0.req;
            w_own_reqtag  = c0.reqtag;
            w_own_respack = c0.respack;
        end
        if (w_grant_idx) begin
            w_pick_wr = c1.reqtag[BUS_TAG_WIDTH-1];
        end else begin
            w_pick_wr = c0.reqtag[BUS_TAG_WIDTH-1];
        end
    end

    // State and transaction bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_is_wr <= 1'b0;
            r_beat  <= {BW{1'b0}};
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
            r_last  <= w_next_last;
            r_is_wr <= w_next_is_wr;
            r_beat  <= w_next_beat;
        end
    end

    // Next-state logic: grant, address beat, then data or response beats.
    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_last  = r_last;
        w_next_is_wr = r_is_wr;
        w_next_beat  = r_beat;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_next_owner = w_grant_idx;
                    w_next_is_wr = w_pick_wr;
                    w_next_beat  = {BW{1'b0}};
                    w_next_state = ADDR;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ADDR: begin
                if (bus.reqack) begin
                    w_next_beat  = {BW{1'b0}};
                    w_next_state = r_is_wr ? WDATA : RESP;
                end else begin
                    w_next_state = ADDR;
                end
            end
            WDATA: begin
                if (bus.reqack) begin
                    w_next_beat = r_beat + BW'(1);
                    if (w_last_beat) begin
                        w_next_state = IDLE;
                        w_next_last  = r_owner;
                    end else begin
                        w_next_state = WDATA;
                    end
                end else begin
                    w_next_state = WDATA;
                end
            end
            RESP: begin
                if (bus.respcyc && w_own_respack) begin
                    w_next_beat = r_beat + BW'(1);
                    if (w_last_beat) begin
                        w_next_state = IDLE;
                        w_next_last  = r_owner;
                    end else begin
                        w_next_state = RESP;
                    end
                end else begin
                    w_next_state = RESP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Beat routing: only the owner ever sees reqack/respcyc.
    always_comb begin
        bus.reqcyc  = 1'b0;
        bus.req     = {BUS_DATA_WIDTH{1'b0}};
        bus.reqtag  = {BUS_TAG_WIDTH{1'b0}};
        bus.respack = 1'b0;
        c0.reqack   = 1'b0;
        c1.reqack   = 1'b0;
        c0.respcyc  = 1'b0;
        c1.respcyc  = 1'b0;
        case (r_state)
            ADDR, WDATA: begin
                bus.reqcyc = w_own_reqcyc;
                bus.req    = w_own_req;
                bus.reqtag = w_own_reqtag;
                if (r_owner) begin
                    c1.reqack = bus.reqack;
                end else begin
                    c0.reqack = bus.reqack;
                end
            end
            RESP: begin
                bus.respack = w_own_respack;
                if (r_owner) begin
                    c1.respcyc = bus.respcyc;
                end else begin
                    c0.respcyc = bus.respcyc;
                end
            end
            default: begin
                bus.reqcyc = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: directed self-checking bench for sysbus_arbiter.
module tb_sysbus_arbiter;

    logic clk;
    logic reset;

    sysbus_arbiter_if c0_if ();
    sysbus_arbiter_if c1_if ();
    sysbus_arbiter_if bus_if ();

    sysbus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .c0    (c0_if),
        .c1    (c1_if),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int req_beats = 0;
    int resp_beats = 0;
    int respack_hi = 0;
    int s0, s1, acc;
    logic e, ra;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted bus beats and any bus respack activity.
    always @(posedge clk) begin
        if (bus_if.reqcyc && bus_if.reqack) req_beats <= req_beats + 1;
        if (bus_if.respcyc && bus_if.respack) resp_beats <= resp_beats + 1;
        if (bus_if.respack) respack_hi <= respack_hi + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        c0_if.reqcyc = 1'b0; c0_if.req = 64'h0; c0_if.reqtag = 13'h0; c0_if.respack = 1'b0;
        c1_if.reqcyc = 1'b0; c1_if.req = 64'h0; c1_if.reqtag = 13'h0; c1_if.respack = 1'b0;
        bus_if.reqack = 1'b0; bus_if.respcyc = 1'b0; bus_if.resp = 64'h0; bus_if.resptag = 13'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bus_reqcyc"}, 64'(bus_if.reqcyc), 64'd0);
        chk({tag, "_bus_req"}, bus_if.req, 64'd0);
        chk({tag, "_bus_reqtag"}, 64'(bus_if.reqtag), 64'd0);
        chk({tag, "_bus_respack"}, 64'(bus_if.respack), 64'd0);
        chk({tag, "_c0_reqack"}, 64'(c0_if.reqack), 64'd0);
        chk({tag, "_c0_respcyc"}, 64'(c0_if.respcyc), 64'd0);
        chk({tag, "_c1_reqack"}, 64'(c1_if.reqack), 64'd0);
        chk({tag, "_c1_respcyc"}, 64'(c1_if.respcyc), 64'd0);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        idle_inputs();
        #1;
        chk_all_zero("in_reset");
        tick(); tick();
        reset = 1'b0;
        settle();
        chk_all_zero("post_reset");

        // Single read by c0
        c0_if.reqcyc = 1'b1; c0_if.req = 64'h1000; c0_if.reqtag = 13'h0005;
        settle();
        chk("rd_T_bus_reqcyc", 64'(bus_if.reqcyc), 64'd0);
        tick(); settle();
        chk("rd_T1_bus_reqcyc", 64'(bus_if.reqcyc), 64'd1);
        chk("rd_T1_bus_req", bus_if.req, 64'h1000);
        chk("rd_T1_bus_reqtag", 64'(bus_if.reqtag), 64'h5);
        chk("rd_T1_c0_reqack", 64'(c0_if.reqack), 64'd0);
        tick(); tick();
        bus_if.reqack = 1'b1;
        settle();
        chk("rd_T3_c0_reqack", 64'(c0_if.reqack), 64'd1);
        chk("rd_T3_c1_reqack", 64'(c1_if.reqack), 64'd0);
        s0 = resp_beats;
        tick();
        bus_if.reqack = 1'b0;
        c0_if.reqcyc = 1'b0; c0_if.req = 64'h0; c0_if.reqtag = 13'h0;
        c0_if.respack = 1'b1; c1_if.respack = 1'b1;
        settle();
        chk("rd_resp_bus_reqcyc", 64'(bus_if.reqcyc), 64'd0);
        for (int i = 0; i < 8; i++) begin
            bus_if.respcyc = 1'b1; bus_if.resp = 64'hA0 + 64'(i); bus_if.resptag = 13'h0005;
            settle();
            chk("rd_c0_respcyc", 64'(c0_if.respcyc), 64'd1);
            chk("rd_c0_resp", c0_if.resp, 64'hA0 + 64'(i));
            chk("rd_c1_respcyc", 64'(c1_if.respcyc), 64'd0);
            chk("rd_bus_respack", 64'(bus_if.respack), 64'd1);
            tick();
        end
        // Stray response beats in IDLE
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stray_bus_respack", 64'(bus_if.respack), 64'd0);
            chk("stray_c0_respcyc", 64'(c0_if.respcyc), 64'd0);
            chk("stray_c1_respcyc", 64'(c1_if.respcyc), 64'd0);
            chk("stray_bus_reqcyc", 64'(bus_if.reqcyc), 64'd0);
            tick();
        end
        chk("rd_resp_beats", 64'(resp_beats - s0), 64'd8);
        bus_if.respcyc = 1'b0;

        // Write by c1: address + 8 data beats, no response phase
        s0 = req_beats; s1 = respack_hi;
        c1_if.reqcyc = 1'b1; c1_if.req = 64'h2000; c1_if.reqtag = 13'h1003;
        bus_if.reqack = 1'b1;
        settle();
        chk("wr_idle_c1_reqack", 64'(c1_if.reqack), 64'd0);
        tick(); settle();
        chk("wr_addr_bus_req", bus_if.req, 64'h2000);
        chk("wr_addr_bus_reqtag", 64'(bus_if.reqtag), 64'h1003);
        chk("wr_addr_c1_reqack", 64'(c1_if.reqack), 64'd1);
        chk("wr_addr_c0_reqack", 64'(c0_if.reqack), 64'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            c1_if.req = 64'hD0 + 64'(i);
            settle();
            chk("wr_data_bus_req", bus_if.req, 64'hD0 + 64'(i));
            chk("wr_data_c1_reqack", 64'(c1_if.reqack), 64'd1);
            chk("wr_data_c1_respcyc", 64'(c1_if.respcyc), 64'd0);
        end
        tick();
        c1_if.reqcyc = 1'b0; bus_if.reqack = 1'b0;
        settle();
        chk("wr_done_bus_reqcyc", 64'(bus_if.reqcyc), 64'd0);
        chk("wr_req_beats", 64'(req_beats - s0), 64'd9);
        chk("wr_no_respack", 64'(respack_hi - s1), 64'd0);
        tick();

        // Contention from reset: alternating 0,1,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        c0_if.reqcyc = 1'b1; c0_if.req = 64'h3000; c0_if.reqtag = 13'h0;
        c1_if.reqcyc = 1'b1; c1_if.req = 64'h4000; c1_if.reqtag = 13'h0;
        bus_if.reqack = 1'b1;
        for (int t = 0; t < 4; t++) begin
            e = (t % 2) == 1;
            settle();
            chk("ct_idle_c0_reqack", 64'(c0_if.reqack), 64'd0);
            tick(); settle();
            chk("ct_bus_req", bus_if.req, e ? 64'h4000 : 64'h3000);
            chk("ct_c0_reqack", 64'(c0_if.reqack), e ? 64'd0 : 64'd1);
            chk("ct_c1_reqack", 64'(c1_if.reqack), e ? 64'd1 : 64'd0);
            tick();
            bus_if.respcyc = 1'b1;
            for (int b = 0; b < 8; b++) begin
                bus_if.resp = 64'(b);
                settle();
                chk("ct_owner_respcyc", 64'(e ? c1_if.respcyc : c0_if.respcyc), 64'd1);
                chk("ct_other_respcyc", 64'(e ? c0_if.respcyc : c1_if.respcyc), 64'd0);
                tick();
            end
            bus_if.respcyc = 1'b0;
        end
        c0_if.reqcyc = 1'b0; c1_if.reqcyc = 1'b0; bus_if.reqack = 1'b0;

        // Backpressure: 5-cycle reqack delay, respack low on beats 3 and 6
        c0_if.req = 64'h5000;
        c0_if.reqcyc = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("bp_wait_c0_reqack", 64'(c0_if.reqack), 64'd0);
            chk("bp_wait_bus_reqcyc", 64'(bus_if.reqcyc), 64'd1);
            tick();
        end
        bus_if.reqack = 1'b1;
        settle();
        chk("bp_c0_reqack", 64'(c0_if.reqack), 64'd1);
        tick();
        bus_if.reqack = 1'b0; c0_if.reqcyc = 1'b0;
        s0 = resp_beats;
        acc = 0;
        bus_if.respcyc = 1'b1;
        for (int c = 0; c < 10; c++) begin
            ra = (c != 3) && (c != 7);
            c0_if.respack = ra;
            bus_if.resp = 64'hB0 + 64'(acc);
            settle();
            chk("bp_c0_respcyc", 64'(c0_if.respcyc), 64'd1);
            chk("bp_bus_respack", 64'(bus_if.respack), 64'(ra));
            tick();
            if (ra) acc++;
        end
        c0_if.respack = 1'b1;
        settle();
        chk("bp_idle_c0_respcyc", 64'(c0_if.respcyc), 64'd0);
        chk("bp_resp_beats", 64'(resp_beats - s0), 64'd8);
        bus_if.respcyc = 1'b0;
        tick();

        // Reset in the middle of a response phase
        c0_if.reqcyc = 1'b1; c0_if.req = 64'h6000;
        tick();
        bus_if.reqack = 1'b1;
        tick();
        bus_if.reqack = 1'b0; c0_if.reqcyc = 1'b0;
        bus_if.respcyc = 1'b1;
        for (int b = 0; b < 4; b++) tick();
        settle();
        chk("mr_pre_c0_respcyc", 64'(c0_if.respcyc), 64'd1);
        reset = 1'b1;
        settle();
        chk_all_zero("mr_reset");
        tick();
        reset = 1'b0;
        settle();
        chk("mr_late_bus_respack", 64'(bus_if.respack), 64'd0);
        chk("mr_late_c0_respcyc", 64'(c0_if.respcyc), 64'd0);
        tick();
        bus_if.respcyc = 1'b0;
        c1_if.reqcyc = 1'b1; c1_if.req = 64'h7000; c1_if.reqtag = 13'h0002;
        tick();
        bus_if.reqack = 1'b1;
        settle();
        chk("mr_c1_bus_req", bus_if.req, 64'h7000);
        chk("mr_c1_reqack", 64'(c1_if.reqack), 64'd1);
        tick();
        bus_if.reqack = 1'b0; c1_if.reqcyc = 1'b0;
        s0 = resp_beats;
        bus_if.respcyc = 1'b1;
        for (int b = 0; b < 8; b++) begin
            bus_if.resp = 64'hC0 + 64'(b);
            settle();
            chk("mr_c1_respcyc", 64'(c1_if.respcyc), 64'd1);
            chk("mr_c1_resp", c1_if.resp, 64'hC0 + 64'(b));
            chk("mr_c0_respcyc", 64'(c0_if.respcyc), 64'd0);
            tick();
        end
        settle();
        chk("mr_idle_c1_respcyc", 64'(c1_if.respcyc), 64'd0);
        chk("mr_resp_beats", 64'(resp_beats - s0), 64'd8);
        bus_if.respcyc = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sysbus_arbiter.md
# sysbus_arbiter

Two-requester arbiter sharing the single system-bus master port of `top` between the instruction-fetch path (requester 0) and the data-cache path (requester 1). Grants one whole transaction at a time: a read (address beat, then BEATS response beats) or a write (address beat, then BEATS data beats). Uses round-robin priority, forwards the owner's request beats to the bus and routes response beats back to the owner only.

## Interface
- `BUS_DATA_WIDTH`, 64: request/response data width.
- `BUS_TAG_WIDTH`, 13: tag width. Tag bit [BUS_TAG_WIDTH-1] = 1 marks a write.
- `BEATS`, 8: data beats per transaction (one 64-byte line).
- `clk`  in  1: clock; single clock domain.
- `reset`  in  1: asynchronous, active-high reset.
- `cN_reqcyc`  in  1: requester N (N=0,1) request beat valid.
- `cN_req`  in  BUS_DATA_WIDTH: requester N address beat, or write data beat.
- `cN_reqtag`  in  BUS_TAG_WIDTH: requester N tag; sampled on the address beat.
- `cN_reqack`  out  1: requester N beat accepted.
- `cN_respcyc`  out  1: response beat valid for requester N.
- `cN_resp`  out  BUS_DATA_WIDTH: response data; wired from `bus_resp`.
- `cN_resptag`  out  BUS_TAG_WIDTH: response tag; wired from `bus_resptag`.
- `cN_respack`  in  1: requester N accepts the response beat.
- `bus_reqcyc`, `bus_req`, `bus_reqtag`  out: system-bus request side.
- `bus_reqack`  in  1: system-bus request acknowledge.
- `bus_respcyc`, `bus_resp`, `bus_resptag`  in: system-bus response side.
- `bus_respack`  out  1: system-bus response acknowledge.

## Operation
- States: IDLE, ADDR, WDATA, RESP.
- Registers: `owner` (1b), `last` (1b, reset 1), `is_wr`, `beat` (log2(BEATS)+1 bits).
- IDLE:
  - If any `cN_reqcyc` is high, pick the requester; a tie goes to the requester that is not `last`.
  - Set `owner`, latch `is_wr` from the tag MSB, move to ADDR.
- ADDR:
  - `bus_reqcyc`=`c[owner]_reqcyc`; `bus_req` and `bus_reqtag` are muxed from the owner's inputs.
  - On `bus_reqack`: go to WDATA if `is_wr`, else RESP. Clear `beat`.
- WDATA:
  - The owner drives data beats on `cN_req`/`cN_reqcyc`.
  - Each `bus_reqack` increments `beat`.
  - At `beat`==BEATS-1 with ack: go to IDLE and set `last`=`owner`.
- RESP:
  - `c[owner]_respcyc`=`bus_respcyc`; `bus_respack`=`c[owner]_respack`.
  - Each cycle with `bus_respcyc`&`bus_respack` increments `beat`.
  - On the BEATS-th beat: go to IDLE and set `last`=`owner`.
- Routing:
  - `c[owner]_reqack`=`bus_reqack` in ADDR/WDATA only.
  - The non-owner sees `reqack`=0 and `respcyc`=0 at all times.
- Outside ADDR/WDATA, `bus_reqcyc`=0 and `bus_req`/`bus_reqtag`=0.
- `bus_respcyc` outside RESP is not acknowledged (`bus_respack`=0) and not routed.
- Requester obligations:
  - Hold `reqcyc`/`req`/`reqtag` stable until its `reqack`.
  - A requester dropping `reqcyc` while owning the bus stalls the transaction; it is not aborted.
- One transaction in flight; no pipelining of the next address beat under the response.

## Timing
- All outputs are reset to 0 asynchronously: `bus_reqcyc`, `bus_req`, `bus_reqtag`, `bus_respack`, `cN_reqack`, `cN_respcyc`.
- `cN_resp`/`cN_resptag` are combinational pass-through and are not reset.
- State, `owner`, `beat` and `is_wr` reset to IDLE/0; `last` resets to 1, so requester 0 wins the first tie.
- Grant latency: `cN_reqcyc` high in IDLE at cycle T gives `bus_reqcyc` high at T+1.
- `reqack` and `respack` paths are combinational, with zero added latency per beat.
- After the final beat, IDLE is entered the next cycle, so the next `bus_reqcyc` is at the earliest 2 cycles after the final beat.
- A requester raising `reqcyc` during another's transaction waits; it wins in the following IDLE.
- Reset mid-transaction:
  - Immediate IDLE; outputs go to 0.
  - Late bus response beats are ignored and not acknowledged.
  - Requesters must also be reset.

## Structure
- `sysbus_pkg`:
  - `BEATS`, `TAG_WRITE_BIT`.
  - `arb_state_t` enum {IDLE, ADDR, WDATA, RESP}.
  - Shared with the cache controllers.
- Sub-module `rr_pick2`: combinational 2-way round-robin picker (inputs: req[1:0], last; outputs: grant_valid, grant_idx).
- Everything else lives in `sysbus_arbiter`.

## Test plan
- Single read: c0 read addr 0x1000 at T → bus_reqcyc at T+1; reqack at T+3 → 8 bus_resp beats 0xA0..0xA7 reach c0 only, c1_respcyc stays 0, then IDLE.
- Write: c1 write tag MSB=1, addr 0x2000 + 8 data beats → bus sees 9 acked request beats in order, no response phase, `bus_respack` stays 0.
- Contention: c0 and c1 request in the same cycle from reset → c0 granted first, c1 next; repeated simultaneous requests alternate 0,1,0,1.
- Backpressure: bus_reqack delayed 5 cycles and c0_respack low on beats 3 and 6 → beats not counted while low, exactly 8 accepted beats, then IDLE.
- Stray response: bus_respcyc pulsed in IDLE → `bus_respack`=0, no cN_respcyc, state unchanged.
- Reset mid-RESP after beat 4 → all outputs 0 in the same cycle; after release, a c1 read completes normally with 8 beats.
